// File: rtl/mac_pkg.sv
// Shared types and constants for the MAC column datapath.
// Optional build macro used by mac_col_drain: MAC_COL_DRAIN_NAN_FLAG_EN.
package mac_pkg;

   typedef logic [15:0] bf16_t;

   localparam int BF16_EXP_MSB = 14;
   localparam int BF16_EXP_LSB = 7;

   typedef enum logic {
      EMPTY = 1'b0,
      DRAIN = 1'b1
   } drain_state_e;

   // An all-ones exponent marks both Inf and NaN encodings.
   function automatic logic bf16_is_inf_nan(input bf16_t word);
      return (word[BF16_EXP_MSB:BF16_EXP_LSB] == 8'hFF);
   endfunction

endpackage

// File: rtl/mac_capture_bank.sv
// Per-cell capture registers for one column: first result per cell is kept,
// a second pulse before the set is transferred is dropped and flagged.
module mac_capture_bank
   import mac_pkg::*;
#(
   parameter int NUM_CELLS = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_CELLS-1:0]    cell_valid,
   input  logic [NUM_CELLS*16-1:0] cell_bf,
   input  logic                    clr,
   output logic [NUM_CELLS*16-1:0] cap_data,
   output logic                    all_cap,
   output logic                    overrun
);

   bf16_t                cap_reg_r [NUM_CELLS];
   logic [NUM_CELLS-1:0] cap_flag_r;

   // Capture each cell's first result; transfer empties the bank. A pulse in
   // the transfer cycle sees the flag still set and counts as an overrun.
   always_ff @(posedge clk) begin
      if (rst) begin
         cap_flag_r <= '0;
         overrun    <= 1'b0;
         for (int i = 0; i < NUM_CELLS; i++) begin
            cap_reg_r[i] <= 16'h0000;
         end
      end else begin
         overrun <= overrun | (|(cell_valid & cap_flag_r));
         for (int i = 0; i < NUM_CELLS; i++) begin
            if (clr) begin
               cap_flag_r[i] <= 1'b0;
            end else if (cell_valid[i] && !cap_flag_r[i]) begin
               cap_reg_r[i]  <= cell_bf[i*16 +: 16];
               cap_flag_r[i] <= 1'b1;
            end
         end
      end
   end

   assign all_cap = &cap_flag_r;

   // Flatten the capture array for the transfer into the drain buffer.
   always_comb begin
      cap_data = '0;
      for (int i = 0; i < NUM_CELLS; i++) begin
         cap_data[i*16 +: 16] = cap_reg_r[i];
      end
   end

endmodule

// File: rtl/mac_col_drain.sv
// Column result drain: collects skewed per-cell results, transfers the full
// set into a drain buffer and streams it out one word per handshake.
// Optional macro MAC_COL_DRAIN_NAN_FLAG_EN adds the sticky nan_seen output.
module mac_col_drain
   import mac_pkg::*;
#(
   parameter int NUM_CELLS = 4,
   parameter int IDX_W     = $clog2(NUM_CELLS)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_CELLS-1:0]    cell_valid,
   input  logic [NUM_CELLS*16-1:0] cell_bf,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [15:0]             out_data,
   output logic [IDX_W-1:0]        out_idx,
   output logic                    out_last,
   output logic                    clear_accum_o,
   output logic                    overrun
`ifdef MAC_COL_DRAIN_NAN_FLAG_EN
   ,output logic                   nan_seen
`endif
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CELLS - 1);

   logic [NUM_CELLS*16-1:0] cap_data_s;
   logic                    all_cap_s;
   logic                    transfer_s;
   logic                    hs_s;
   drain_state_e            state_r;
   drain_state_e            state_nxt_s;
   logic [IDX_W-1:0]        cnt_r;
   logic [IDX_W-1:0]        cnt_nxt_s;
   bf16_t                   out_data_nxt_s;
   bf16_t                   drn_r [NUM_CELLS];

   mac_capture_bank #(
      .NUM_CELLS (NUM_CELLS)
   ) u_capture (
      .clk        (clk),
      .rst        (rst),
      .cell_valid (cell_valid),
      .cell_bf    (cell_bf),
      .clr        (transfer_s),
      .cap_data   (cap_data_s),
      .all_cap    (all_cap_s),
      .overrun    (overrun)
   );

   assign hs_s       = out_valid & out_ready;
   assign transfer_s = all_cap_s & (state_r == EMPTY);

   // Drain FSM next state and next output word (word 0 comes straight from
   // the capture bank on transfer since the drain buffer loads on that edge).
   always_comb begin
      state_nxt_s    = state_r;
      cnt_nxt_s      = cnt_r;
      out_data_nxt_s = out_data;
      case (state_r)
         EMPTY: begin
            if (transfer_s) begin
               state_nxt_s = DRAIN;
               cnt_nxt_s   = {IDX_W{1'b0}};
            end else begin
               state_nxt_s = EMPTY;
            end
         end
         DRAIN: begin
            if (hs_s) begin
               if (cnt_r == LAST_IDX) begin
                  state_nxt_s = EMPTY;
               end else begin
                  cnt_nxt_s = cnt_r + IDX_W'(1);
               end
            end else begin
               state_nxt_s = DRAIN;
            end
         end
         default: begin
            state_nxt_s = EMPTY;
            cnt_nxt_s   = {IDX_W{1'b0}};
         end
      endcase
      if (transfer_s) begin
         out_data_nxt_s = cap_data_s[15:0];
      end else if (state_nxt_s == DRAIN) begin
         out_data_nxt_s = drn_r[cnt_nxt_s];
      end else begin
         out_data_nxt_s = out_data;
      end
   end

   // Drain buffer snapshots the captured set on transfer.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_CELLS; i++) begin
            drn_r[i] <= 16'h0000;
         end
      end else if (transfer_s) begin
         for (int i = 0; i < NUM_CELLS; i++) begin
            drn_r[i] <= cap_data_s[i*16 +: 16];
         end
      end
   end

   // FSM state, word counter and registered stream outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r       <= EMPTY;
         cnt_r         <= {IDX_W{1'b0}};
         out_valid     <= 1'b0;
         out_data      <= 16'h0000;
         out_idx       <= {IDX_W{1'b0}};
         out_last      <= 1'b0;
         clear_accum_o <= 1'b0;
      end else begin
         state_r       <= state_nxt_s;
         cnt_r         <= cnt_nxt_s;
         out_valid     <= (state_nxt_s == DRAIN);
         out_data      <= out_data_nxt_s;
         out_idx       <= cnt_nxt_s;
         out_last      <= (state_nxt_s == DRAIN) && (cnt_nxt_s == LAST_IDX);
         clear_accum_o <= transfer_s;
      end
   end

`ifdef MAC_COL_DRAIN_NAN_FLAG_EN
   // Sticky flag for any Inf/NaN word accepted by the consumer.
   always_ff @(posedge clk) begin
      if (rst) begin
         nan_seen <= 1'b0;
      end else if (hs_s && bf16_is_inf_nan(out_data)) begin
         nan_seen <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_mac_col_drain.sv
// Self-checking bench for mac_col_drain: table-driven result sets plus
// hand-written latency, back-to-back, overrun, Inf/NaN and reset sequences.
module tb_mac_col_drain;

   localparam int NC = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic [NC-1:0]   cell_valid;
   logic [NC*16-1:0] cell_bf;
   logic            out_valid;
   logic            out_ready;
   logic [15:0]     out_data;
   logic [1:0]      out_idx;
   logic            out_last;
   logic            clear_accum_o;
   logic            overrun;
`ifdef MAC_COL_DRAIN_NAN_FLAG_EN
   logic            nan_seen;
`endif

   typedef struct packed {
      logic [15:0] data;
      logic [1:0]  idx;
      logic        last;
   } exp_t;

   typedef struct {
      logic [63:0] vals;
      logic [63:0] exp_words;
      int          rmode;
   } vec_t;

   exp_t q[$];
   vec_t tbl[3];
   int   n_vec = 0;
   int   n_err = 0;
   int   ready_mode = 0;
   int   clr_cnt = 0;
   int   cyc = 0;

   mac_col_drain #(.NUM_CELLS(NC)) dut (
      .clk           (clk),
      .rst           (rst),
      .cell_valid    (cell_valid),
      .cell_bf       (cell_bf),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_data      (out_data),
      .out_idx       (out_idx),
      .out_last      (out_last),
      .clear_accum_o (clear_accum_o),
      .overrun       (overrun)
`ifdef MAC_COL_DRAIN_NAN_FLAG_EN
      ,.nan_seen     (nan_seen)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Consumer ready pattern: 0 = always ready, 1 = 1,0,0 repeating, 2 = stalled.
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         case (ready_mode)
            1:       out_ready = (cyc % 3 == 0);
            2:       out_ready = 1'b0;
            default: out_ready = 1'b1;
         endcase
      end
   end

   // Monitor: count clear pulses, check holds while stalled, pop scoreboard on handshake.
   initial begin
      logic  stalled_prev;
      exp_t  held;
      exp_t  e;
      stalled_prev = 1'b0;
      held = '0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (clear_accum_o) clr_cnt++;
            if (stalled_prev && out_valid)
               chk("hold", {out_data, out_idx, out_last}, held);
            stalled_prev = out_valid && !out_ready;
            held = {out_data, out_idx, out_last};
            if (out_valid && out_ready) begin
               if (q.size() == 0) begin
                  n_vec++;
                  n_err++;
                  $display("FAIL spurious_word: got %0h idx %0d, expected no word", out_data, out_idx);
               end else begin
                  e = q.pop_front();
                  chk("word", {out_data, out_idx, out_last}, e);
               end
            end
         end else begin
            stalled_prev = 1'b0;
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "timeout");
   end

   task automatic drive_one(input int i, input logic [15:0] v);
      @(posedge clk);
      #1;
      cell_valid    = '0;
      cell_valid[i] = 1'b1;
      cell_bf       = '0;
      cell_bf[i*16 +: 16] = v;
   endtask

   task automatic idle_inputs();
      @(posedge clk);
      #1;
      cell_valid = '0;
      cell_bf    = '0;
   endtask

   task automatic send_set(input logic [63:0] vals, input logic [63:0] expw);
      for (int i = 0; i < NC; i++) begin
         drive_one(i, vals[i*16 +: 16]);
         q.push_back(exp_t'{data: expw[i*16 +: 16], idx: 2'(i), last: (i == NC - 1)});
      end
      idle_inputs();
   endtask

   task automatic wait_drain(input string name);
      int n;
      n = 0;
      while (q.size() != 0 && n < 300) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk({name, "_left"}, q.size(), 0);
      repeat (2) @(negedge clk);
      #1;
   endtask

   task automatic check_reset_vals(input string name);
      chk({name, "_valid"}, out_valid, 0);
      chk({name, "_data"}, out_data, 0);
      chk({name, "_idx"}, out_idx, 0);
      chk({name, "_last"}, out_last, 0);
      chk({name, "_clr"}, clear_accum_o, 0);
      chk({name, "_ovr"}, overrun, 0);
`ifdef MAC_COL_DRAIN_NAN_FLAG_EN
      chk({name, "_nan"}, nan_seen, 0);
`endif
   endtask

   initial begin
      int c0;
      int n;
      logic found;

      tbl[0] = '{vals: 64'h4080_4040_4000_3F80, exp_words: 64'h4080_4040_4000_3F80, rmode: 1};
      tbl[1] = '{vals: 64'hC0A0_0001_8000_3C00, exp_words: 64'hC0A0_0001_8000_3C00, rmode: 0};
      tbl[2] = '{vals: 64'h4049_BF80_7F7F_0000, exp_words: 64'h4049_BF80_7F7F_0000, rmode: 1};

      rst = 1'b1;
      cell_valid = '0;
      cell_bf = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_vals("reset");
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Latency: last cell in cycle 3, out_valid and clear pulse in cycle 5.
      ready_mode = 0;
      c0 = clr_cnt;
      send_set(64'h4080_4040_4000_3F80, 64'h4080_4040_4000_3F80);
      @(negedge clk);
      chk("lat_c4_valid", out_valid, 0);
      @(negedge clk);
      chk("lat_c5_valid", out_valid, 1);
      chk("lat_c5_idx", out_idx, 0);
      chk("lat_c5_clr", clear_accum_o, 1);
      @(negedge clk);
      chk("lat_c6_clr", clear_accum_o, 0);
      wait_drain("lat");
      chk("lat_clr_count", clr_cnt - c0, 1);

      // Table-driven sets, various ready patterns.
      for (int k = 0; k < 3; k++) begin
         ready_mode = tbl[k].rmode;
         c0 = clr_cnt;
         send_set(tbl[k].vals, tbl[k].exp_words);
         wait_drain("tbl");
         chk("tbl_clr_count", clr_cnt - c0, 1);
         chk("tbl_overrun", overrun, 0);
      end

      // Second set captured while first is stalled in DRAIN.
      ready_mode = 2;
      c0 = clr_cnt;
      send_set(64'h4100_C040_3FC0_4010, 64'h4100_C040_3FC0_4010);
      send_set(64'h3E00_4200_C100_4300, 64'h3E00_4200_C100_4300);
      repeat (3) @(negedge clk);
      #1;
      chk("b2b_stalled_idx", out_idx, 0);
      chk("b2b_stalled_clr_count", clr_cnt - c0, 1);
      ready_mode = 0;
      found = 1'b0;
      n = 0;
      while (!found && n < 50) begin
         @(negedge clk);
         #1;
         n++;
         found = out_valid && out_last && out_ready;
      end
      chk("b2b_last_seen", found, 1);
      @(negedge clk);
      chk("b2b_gap_valid", out_valid, 0);
      @(negedge clk);
      chk("b2b_second_valid", out_valid, 1);
      chk("b2b_second_idx", out_idx, 0);
      chk("b2b_second_clr", clear_accum_o, 1);
      wait_drain("b2b");
      chk("b2b_clr_count", clr_cnt - c0, 2);
      chk("b2b_overrun", overrun, 0);

`ifdef MAC_COL_DRAIN_NAN_FLAG_EN
      chk("nan_before", nan_seen, 0);
`endif
      send_set(64'h4080_4040_7FC0_3F80, 64'h4080_4040_7FC0_3F80);
      wait_drain("nan");
`ifdef MAC_COL_DRAIN_NAN_FLAG_EN
      chk("nan_after", nan_seen, 1);
`endif

      // Double pulse on cell 2 before completion: first value kept, overrun set.
      chk("ovr_before", overrun, 0);
      drive_one(0, 16'h1111);
      drive_one(1, 16'h2222);
      drive_one(2, 16'h4000);
      drive_one(2, 16'hBF80);
      drive_one(3, 16'h4444);
      q.push_back(exp_t'{data: 16'h1111, idx: 2'd0, last: 1'b0});
      q.push_back(exp_t'{data: 16'h2222, idx: 2'd1, last: 1'b0});
      q.push_back(exp_t'{data: 16'h4000, idx: 2'd2, last: 1'b0});
      q.push_back(exp_t'{data: 16'h4444, idx: 2'd3, last: 1'b1});
      idle_inputs();
      wait_drain("ovr");
      chk("ovr_after", overrun, 1);

      // Reset mid-drain after two words, then a fresh set from idx 0.
      send_set(64'h4500_4400_4300_4200, 64'h4500_4400_4300_4200);
      found = 1'b0;
      n = 0;
      while (!found && n < 20) begin
         @(negedge clk);
         #1;
         n++;
         found = out_valid && (out_idx == 2'd1);
      end
      chk("rst_mid_seen", found, 1);
      @(posedge clk);
      #1;
      rst = 1'b1;
      q.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check_reset_vals("rst_mid");
      send_set(64'h3D00_3C80_3C00_3B80, 64'h3D00_3C80_3C00_3B80);
      wait_drain("post_rst");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
